// File: rtl/conv_mc_engine.sv
// Multi-channel MxM signed convolution engine: row-beat kernel/window loading, a
// registered multiply / adder-tree / channel-accumulate pipeline, and an optionally saturated output.
module conv_mc_engine #(
  parameter int BIT_LEN  = 8,
  parameter int M_LEN    = 3,
  parameter int N_CH     = 4,
  parameter int OUT_LEN  = 24,
  parameter int SATURATE = 1
) (
  input  logic                     i_clk,
  input  logic                     i_reset_n,
  input  logic                     i_clear,
  input  logic                     i_k_valid,
  input  logic [BIT_LEN*M_LEN-1:0] i_k_data,
  input  logic                     i_img_valid,
  input  logic [BIT_LEN*M_LEN-1:0] i_img_data,
  output logic                     o_k_loaded,
  output logic                     o_valid,
  output logic [OUT_LEN-1:0]       o_data
);

  localparam int NTAP      = M_LEN * M_LEN;
  localparam int ROW_BITS  = BIT_LEN * M_LEN;
  localparam int PROD_LEN  = 2 * BIT_LEN;
  localparam int ACC_LEN   = 2 * BIT_LEN + $clog2(NTAP) + $clog2(N_CH) + 1;
  localparam int CH_W      = (N_CH > 1) ? $clog2(N_CH) : 1;
  localparam int ROW_W     = $clog2(M_LEN);
  localparam int CH_SLOTS  = 1 << CH_W;
  localparam int ROW_SLOTS = 1 << ROW_W;
  localparam int EXT_LEN   = ((ACC_LEN > OUT_LEN) ? ACC_LEN : OUT_LEN) + 1;

  localparam logic [CH_W-1:0]  LAST_CH  = CH_W'(N_CH - 1);
  localparam logic [ROW_W-1:0] LAST_ROW = ROW_W'(M_LEN - 1);
  localparam logic signed [EXT_LEN-1:0] SAT_MAX =
    {{(EXT_LEN - OUT_LEN + 1){1'b0}}, {(OUT_LEN - 1){1'b1}}};
  localparam logic signed [EXT_LEN-1:0] SAT_MIN =
    {{(EXT_LEN - OUT_LEN + 1){1'b1}}, {(OUT_LEN - 1){1'b0}}};

  // Storage is sized to power-of-two slots so counter values index it directly.
  logic [ROW_BITS-1:0] kern_q [CH_SLOTS][ROW_SLOTS];
  logic [ROW_BITS-1:0] win_q  [CH_SLOTS][ROW_SLOTS];

  logic [CH_W-1:0]  kc_q, kc_d, ic_q, ic_d, k_wch;
  logic [ROW_W-1:0] kr_q, kr_d, ir_q, ir_d, k_wrow;
  logic             k_loaded_q, k_loaded_d, k_we, i_we;

  logic             tok_v_q, tok_v_d, tok_first_q, tok_first_d, tok_last_q, tok_last_d;
  logic [CH_W-1:0]  tok_ch_q, tok_ch_d;
  logic             p_v_q, p_v_d, p_first_q, p_last_q;
  logic             s_v_q, s_v_d, s_first_q, s_last_q;

  logic [NTAP*PROD_LEN-1:0]   prod_q;
  logic signed [ACC_LEN-1:0]  sum_c, sum_q, acc_q, acc_d, acc_sum;
  logic signed [EXT_LEN-1:0]  acc_ext;
  logic [OUT_LEN-1:0]         out_c, o_data_q, o_data_d;
  logic                       o_valid_q, o_valid_d;

  // Loader: clear beats a kernel beat, which beats an image beat.
  always_comb begin
    kc_d        = kc_q;
    kr_d        = kr_q;
    ic_d        = ic_q;
    ir_d        = ir_q;
    k_loaded_d  = k_loaded_q;
    k_we        = 1'b0;
    k_wch       = kc_q;
    k_wrow      = kr_q;
    i_we        = 1'b0;
    tok_v_d     = 1'b0;
    tok_ch_d    = tok_ch_q;
    tok_first_d = 1'b0;
    tok_last_d  = 1'b0;
    if (i_clear) begin
      ic_d = '0;
      ir_d = '0;
    end else if (i_k_valid) begin
      k_we = 1'b1;
      ic_d = '0;
      ir_d = '0;
      if (k_loaded_q) begin
        k_wch      = '0;
        k_wrow     = '0;
        k_loaded_d = 1'b0;
        kc_d       = '0;
        kr_d       = ROW_W'(1);
      end else if (kr_q == LAST_ROW) begin
        kr_d = '0;
        if (kc_q == LAST_CH) begin
          kc_d       = '0;
          k_loaded_d = 1'b1;
        end else begin
          kc_d = kc_q + 1'b1;
        end
      end else begin
        kr_d = kr_q + 1'b1;
      end
    end else if (i_img_valid && k_loaded_q) begin
      i_we = 1'b1;
      if (ir_q == LAST_ROW) begin
        ir_d        = '0;
        tok_v_d     = 1'b1;
        tok_ch_d    = ic_q;
        tok_first_d = (ic_q == '0);
        tok_last_d  = (ic_q == LAST_CH);
        ic_d        = (ic_q == LAST_CH) ? '0 : ic_q + 1'b1;
      end else begin
        ir_d = ir_q + 1'b1;
      end
    end
  end

  always_comb begin
    sum_c = '0;
    for (int unsigned t = 0; t < NTAP; t++) begin
      sum_c = sum_c + {{(ACC_LEN - PROD_LEN){prod_q[t*PROD_LEN + PROD_LEN - 1]}},
                       prod_q[t*PROD_LEN +: PROD_LEN]};
    end
  end

  always_comb begin
    acc_sum = s_first_q ? sum_q : acc_q + sum_q;
    acc_ext = {{(EXT_LEN - ACC_LEN){acc_sum[ACC_LEN-1]}}, acc_sum};
    out_c   = acc_ext[OUT_LEN-1:0];
    if (SATURATE != 0) begin
      if (acc_ext > SAT_MAX)      out_c = SAT_MAX[OUT_LEN-1:0];
      else if (acc_ext < SAT_MIN) out_c = SAT_MIN[OUT_LEN-1:0];
    end
  end

  always_comb begin
    p_v_d     = tok_v_q && !i_clear;
    s_v_d     = p_v_q && !i_clear;
    acc_d     = acc_q;
    o_valid_d = 1'b0;
    o_data_d  = o_data_q;
    if (i_clear) begin
      acc_d = '0;
    end else if (s_v_q) begin
      acc_d = acc_sum;
      if (s_last_q) begin
        o_valid_d = 1'b1;
        o_data_d  = out_c;
      end
    end
  end

  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      kc_q        <= '0;
      kr_q        <= '0;
      ic_q        <= '0;
      ir_q        <= '0;
      k_loaded_q  <= 1'b0;
      tok_v_q     <= 1'b0;
      tok_ch_q    <= '0;
      tok_first_q <= 1'b0;
      tok_last_q  <= 1'b0;
      p_v_q       <= 1'b0;
      p_first_q   <= 1'b0;
      p_last_q    <= 1'b0;
      s_v_q       <= 1'b0;
      s_first_q   <= 1'b0;
      s_last_q    <= 1'b0;
      acc_q       <= '0;
      o_valid_q   <= 1'b0;
      o_data_q    <= '0;
    end else begin
      kc_q        <= kc_d;
      kr_q        <= kr_d;
      ic_q        <= ic_d;
      ir_q        <= ir_d;
      k_loaded_q  <= k_loaded_d;
      tok_v_q     <= tok_v_d;
      tok_ch_q    <= tok_ch_d;
      tok_first_q <= tok_first_d;
      tok_last_q  <= tok_last_d;
      p_v_q       <= p_v_d;
      p_first_q   <= tok_first_q;
      p_last_q    <= tok_last_q;
      s_v_q       <= s_v_d;
      s_first_q   <= p_first_q;
      s_last_q    <= p_last_q;
      acc_q       <= acc_d;
      o_valid_q   <= o_valid_d;
      o_data_q    <= o_data_d;
    end
  end

  // Data-only registers: contents are qualified by the valids above, so no reset.
  always_ff @(posedge i_clk) begin
    if (k_we) kern_q[k_wch][k_wrow] <= i_k_data;
    if (i_we) win_q[ic_q][ir_q] <= i_img_data;
    for (int unsigned r = 0; r < M_LEN; r++) begin
      for (int unsigned c = 0; c < M_LEN; c++) begin
        prod_q[(r*M_LEN + c)*PROD_LEN +: PROD_LEN] <=
          $signed(kern_q[tok_ch_q][ROW_W'(r)][c*BIT_LEN +: BIT_LEN]) *
          $signed(win_q[tok_ch_q][ROW_W'(r)][c*BIT_LEN +: BIT_LEN]);
      end
    end
    sum_q <= sum_c;
  end

  assign o_k_loaded = k_loaded_q;
  assign o_valid    = o_valid_q;
  assign o_data     = o_data_q;

endmodule

// File: doc/conv_mc_engine.md
Name: conv_mc_engine

Overview:
- Parametrised, multi-channel successor of the single 3x3 convolution cell.
- Holds N_CH signed MxM kernels and accepts an MxM image window per channel, one row per beat.
- Runs a pipelined multiply / adder-tree / channel-accumulate datapath and emits one valid-qualified result per complete N_CH-channel window set.
- Sits between the line-buffer/window generator and the activation/pooling stage.

Parameters:
- BIT_LEN, 8: width of one signed two's-complement pixel/weight.
- M_LEN, 3: kernel/window side; any value >= 2.
- N_CH, 4: input channels accumulated per output; any value >= 1.
- OUT_LEN, 24: output width.
- SATURATE, 1: 1 = clamp to the signed OUT_LEN range; 0 = wrap modulo 2^OUT_LEN.
- Derived, local: ACC_LEN = 2*BIT_LEN + clog2(M_LEN*M_LEN) + clog2(N_CH) + 1, the full-precision internal width.

Ports:
- i_clk, input, 1: clock; all state changes on its rising edge.
- i_reset_n, input, 1: asynchronous active-low reset.
- i_clear, input, 1: synchronous flush of image counters and pipeline; kernels are kept.
- i_k_valid, input, 1: kernel row beat.
- i_k_data, input, BIT_LEN*M_LEN: kernel row. Element e occupies bits [(e+1)*BIT_LEN-1 -: BIT_LEN].
- i_img_valid, input, 1: image row beat.
- i_img_data, input, BIT_LEN*M_LEN: image row, same packing as i_k_data.
- o_k_loaded, output, 1: all N_CH*M_LEN kernel rows are present.
- o_valid, output, 1: one-cycle pulse; o_data is new in this cycle.
- o_data, output, OUT_LEN: signed convolution sum over all channels.

Behaviour:
- Reset (i_reset_n=0, asynchronous):
  - o_valid=0, o_k_loaded=0, o_data=0.
  - Kernel and image counters 0; all pipeline valids 0.
  - Kernel/window storage need not be cleared.
- Kernel load:
  - Each i_k_valid beat writes row kr of channel kc; order is ch0 row0..row M_LEN-1, then ch1, and so on.
  - After beat N_CH*M_LEN, o_k_loaded rises on the next cycle and the counters wrap to 0.
  - An i_k_valid beat while o_k_loaded=1 starts a reload: o_k_loaded drops that edge and the beat is written as ch0 row0.
  - Any i_k_valid beat resets the image counters to 0, discarding a partial window.
- Image load:
  - i_img_valid is ignored while o_k_loaded=0.
  - Otherwise the beat writes row ir of channel ic's window register; order matches the kernel order.
- Simultaneous events (highest priority first): reset > i_clear > i_k_valid > i_img_valid. A dropped image beat is lost.
- Window completion: the beat writing row M_LEN-1 of channel ic launches a pipeline token tagged first=(ic==0) and last=(ic==N_CH-1).
- Pipeline (edge T captures the final row):
  - T+1: M_LEN*M_LEN signed products, each 2*BIT_LEN wide, registered.
  - T+2: adder-tree sum, registered, sign-extended to ACC_LEN.
  - T+3: accumulator <= first ? sum : acc+sum. If last, o_data is updated and o_valid=1 for that cycle.
- Latency and throughput:
  - o_valid is high in the cycle after edge T+3, i.e. 3 clocks after the last row is captured.
  - One row beat per clock is accepted with no stall, so the sustained rate is one output per N_CH*M_LEN beats.
  - Tokens for consecutive channels may be in flight together.
- Output width rules:
  - SATURATE=1: the ACC_LEN result is clamped to [-2^(OUT_LEN-1), 2^(OUT_LEN-1)-1].
  - SATURATE=0: the low OUT_LEN bits are taken.
- o_data holds its value between o_valid pulses.
- i_clear: image counters to 0, all pipeline valids to 0 (in-flight results are never output), accumulator to 0. o_data is held; kernels and o_k_loaded are unchanged.
- Kernel reload does not cancel in-flight tokens: products already registered complete normally.

Test Plan:
- N_CH=1, kernel all 1, image rows {1,2,3},{4,5,6},{7,8,9} on consecutive clocks -> o_valid exactly 3 clocks after the third row, o_data=45, single-cycle pulse.
- Defaults; kernels and images all -128 on 4 channels -> o_data=589824 once, after 12 image beats; o_valid is 0 after the channel 0..2 windows.
- N_CH=1, OUT_LEN=16, kernel and image all 127:
  - SATURATE=1 -> 32767.
  - SATURATE=0 -> 14089.
- Image beats before the kernel is loaded -> no o_valid. i_clear after 5 of 12 image beats, then 12 fresh beats -> exactly one o_valid, using only the fresh data.
- Back-to-back windows, 24 image beats at defaults -> o_valid pulses exactly 12 clocks apart with correct independent sums. A kernel reload beat mid-window -> o_k_loaded drops and the partial window is discarded.
- i_reset_n pulsed low mid-pipeline -> o_valid, o_data and o_k_loaded go to 0 immediately, with no output after release until the kernel is reloaded and a full window is supplied.
